// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480 timing, the 16-colour palette
// (12-bit RGB, 4 bits per channel) and the pattern mode encodings.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam logic [1:0] MODE_SOLID    = 2'd0;
    localparam logic [1:0] MODE_BARS     = 2'd1;
    localparam logic [1:0] MODE_CHECKER  = 2'd2;
    localparam logic [1:0] MODE_GRADIENT = 2'd3;

    // Entries are {R[3:0], G[3:0], B[3:0]}; narrower channels keep the MSBs.
    localparam logic [11:0] PALETTE [16] = '{
        12'h000, 12'h00A, 12'h0A0, 12'h0AA,
        12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
        12'h555, 12'h55F, 12'h5F5, 12'h5FF,
        12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
    };

    function automatic int frame_total(input int active, input int fp,
                                       input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int DEF_H_TOTAL = frame_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL = frame_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_pattern_gen.sv
// Combinational test-pattern generator: maps mode, palette index and the
// current pixel coordinate to an RGB colour. COLOR_W must not exceed 4.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int COLOR_W  = 4
)(
    input  logic [1:0]         i_mode,
    input  logic [3:0]         i_sw,
    input  logic [9:0]         i_pix_x,
    input  logic [9:0]         i_pix_y,
    output logic [COLOR_W-1:0] o_r,
    output logic [COLOR_W-1:0] o_g,
    output logic [COLOR_W-1:0] o_b
);

    localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);

    logic [2:0]  w_bar_idx;
    logic [11:0] w_sw_rgb;
    logic [11:0] w_bar_rgb;

    assign w_bar_idx = 3'(i_pix_x / BAR_W);
    assign w_sw_rgb  = PALETTE[i_sw];
    assign w_bar_rgb = PALETTE[{1'b0, w_bar_idx}];

    // Pattern select; the checkerboard shows black where bit 5 of x and y differ.
    always_comb begin
        o_r = '0;
        o_g = '0;
        o_b = '0;
        case (i_mode)
            MODE_SOLID: begin
                o_r = w_sw_rgb[11 -: COLOR_W];
                o_g = w_sw_rgb[7 -: COLOR_W];
                o_b = w_sw_rgb[3 -: COLOR_W];
            end
            MODE_BARS: begin
                o_r = w_bar_rgb[11 -: COLOR_W];
                o_g = w_bar_rgb[7 -: COLOR_W];
                o_b = w_bar_rgb[3 -: COLOR_W];
            end
            MODE_CHECKER: begin
                if (i_pix_x[5] ^ i_pix_y[5]) begin
                    o_r = '0;
                    o_g = '0;
                    o_b = '0;
                end else begin
                    o_r = w_sw_rgb[11 -: COLOR_W];
                    o_g = w_sw_rgb[7 -: COLOR_W];
                    o_b = w_sw_rgb[3 -: COLOR_W];
                end
            end
            MODE_GRADIENT: begin
                o_r = i_pix_x[9 -: COLOR_W];
                o_g = i_pix_y[9 -: COLOR_W];
                o_b = '0;
            end
            default: begin
                o_r = '0;
                o_g = '0;
                o_b = '0;
            end
        endcase
    end

endmodule

// File: rtl/vga_timing_gen_p.sv
// VGA timing generator: pixel-clock divider, h/v counters, sync/blanking
// decode and registered outputs, with a pattern generator for the colour.
module vga_timing_gen_p
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CLK_DIV  = 2,
    parameter int COLOR_W  = 4
)(
    input  logic               clk_50,
    input  logic               rst_o,
    input  logic [3:0]         sw,
    input  logic [1:0]         mode,
    output logic               hsync,
    output logic               vsync,
    output logic [COLOR_W-1:0] R,
    output logic [COLOR_W-1:0] G,
    output logic [COLOR_W-1:0] B,
    output logic               video_on,
    output logic [9:0]         pix_x,
    output logic [9:0]         pix_y,
    output logic               frame_start
);

    localparam int H_TOTAL = frame_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = frame_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT   = 11'(V_ACTIVE);
    localparam logic [10:0] H_SS    = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SE    = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_SS    = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SE    = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic        HS_ACT  = 1'(HS_POL);
    localparam logic        VS_ACT  = 1'(VS_POL);

    logic [DIV_W-1:0]   r_div;
    logic [10:0]        r_hc;
    logic [10:0]        r_vc;
    logic [1:0]         r_mode_q;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_video_on;
    logic               r_frame_start;
    logic [9:0]         r_pix_x;
    logic [9:0]         r_pix_y;
    logic [COLOR_W-1:0] r_r;
    logic [COLOR_W-1:0] r_g;
    logic [COLOR_W-1:0] r_b;

    logic               w_pix_en;
    logic               w_origin;
    logic               w_video;
    logic               w_hs_region;
    logic               w_vs_region;
    logic [1:0]         w_mode_eff;
    logic [COLOR_W-1:0] w_pat_r;
    logic [COLOR_W-1:0] w_pat_g;
    logic [COLOR_W-1:0] w_pat_b;

    // Ticking at divider zero makes the first edge after reset a pixel tick.
    assign w_pix_en    = (r_div == '0);
    assign w_origin    = (r_hc == 11'd0) && (r_vc == 11'd0);
    assign w_video     = (r_hc < H_ACT) && (r_vc < V_ACT);
    assign w_hs_region = (r_hc >= H_SS) && (r_hc < H_SE);
    assign w_vs_region = (r_vc >= V_SS) && (r_vc < V_SE);
    // The origin pixel already uses the freshly captured mode so no frame tears.
    assign w_mode_eff  = w_origin ? mode : r_mode_q;

    vga_pattern_gen #(
        .H_ACTIVE (H_ACTIVE),
        .COLOR_W  (COLOR_W)
    ) u_pattern (
        .i_mode  (w_mode_eff),
        .i_sw    (sw),
        .i_pix_x (r_hc[9:0]),
        .i_pix_y (r_vc[9:0]),
        .o_r     (w_pat_r),
        .o_g     (w_pat_g),
        .o_b     (w_pat_b)
    );

    // Pixel-clock divider.
    always_ff @(posedge clk_50) begin
        if (!rst_o) begin
            r_div <= '0;
        end else if (r_div == DIV_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Horizontal/vertical counters; vc steps on the same tick hc wraps.
    always_ff @(posedge clk_50) begin
        if (!rst_o) begin
            r_hc <= 11'd0;
            r_vc <= 11'd0;
        end else if (w_pix_en) begin
            if (r_hc == H_LAST) begin
                r_hc <= 11'd0;
                if (r_vc == V_LAST) begin
                    r_vc <= 11'd0;
                end else begin
                    r_vc <= r_vc + 11'd1;
                end
            end else begin
                r_hc <= r_hc + 11'd1;
            end
        end
    end

    // Frame-synchronous mode capture.
    always_ff @(posedge clk_50) begin
        if (!rst_o) begin
            r_mode_q <= MODE_SOLID;
        end else if (w_pix_en && w_origin) begin
            r_mode_q <= mode;
        end
    end

    // Output register stage: one pixel tick behind hc/vc, all aligned.
    always_ff @(posedge clk_50) begin
        if (!rst_o) begin
            r_hsync       <= ~HS_ACT;
            r_vsync       <= ~VS_ACT;
            r_video_on    <= 1'b0;
            r_frame_start <= 1'b0;
            r_pix_x       <= 10'd0;
            r_pix_y       <= 10'd0;
            r_r           <= '0;
            r_g           <= '0;
            r_b           <= '0;
        end else if (w_pix_en) begin
            r_hsync       <= w_hs_region ? HS_ACT : ~HS_ACT;
            r_vsync       <= w_vs_region ? VS_ACT : ~VS_ACT;
            r_video_on    <= w_video;
            r_frame_start <= w_origin;
            r_pix_x       <= w_video ? r_hc[9:0] : 10'd0;
            r_pix_y       <= w_video ? r_vc[9:0] : 10'd0;
            r_r           <= w_video ? w_pat_r : '0;
            r_g           <= w_video ? w_pat_g : '0;
            r_b           <= w_video ? w_pat_b : '0;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign video_on    = r_video_on;
    assign frame_start = r_frame_start;
    assign pix_x       = r_pix_x;
    assign pix_y       = r_pix_y;
    assign R           = r_r;
    assign G           = r_g;
    assign B           = r_b;

endmodule

// File: tb/tb_vga_timing_gen_p.sv
// Directed bench for vga_timing_gen_p: five instances (default, inverted
// polarity, two 64-pixel-wide frames, tiny timing) exercised in parallel.
module tb_vga_timing_gen_p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    logic [4:0]      rstn = '0;
    logic [4:0][3:0] swv  = '0;
    logic [4:0][1:0] mdv  = '0;
    wire  [4:0]      hs, vs, von, fs;
    wire  [4:0][3:0] rr, gg, bb;
    wire  [4:0][9:0] px, py;

    // 0: defaults (CLK_DIV=2)
    vga_timing_gen_p u_def (
        .clk_50(clk), .rst_o(rstn[0]), .sw(swv[0]), .mode(mdv[0]),
        .hsync(hs[0]), .vsync(vs[0]), .R(rr[0]), .G(gg[0]), .B(bb[0]),
        .video_on(von[0]), .pix_x(px[0]), .pix_y(py[0]), .frame_start(fs[0]));

    // 1: inverted sync polarity, one clock per pixel
    vga_timing_gen_p #(.HS_POL(1), .VS_POL(1), .CLK_DIV(1)) u_pol (
        .clk_50(clk), .rst_o(rstn[1]), .sw(swv[1]), .mode(mdv[1]),
        .hsync(hs[1]), .vsync(vs[1]), .R(rr[1]), .G(gg[1]), .B(bb[1]),
        .video_on(von[1]), .pix_x(px[1]), .pix_y(py[1]), .frame_start(fs[1]));

    // 2: 80-pixel lines, full 525-line frame (mode switch, vsync, frame period)
    vga_timing_gen_p #(.H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4), .CLK_DIV(1)) u_mid (
        .clk_50(clk), .rst_o(rstn[2]), .sw(swv[2]), .mode(mdv[2]),
        .hsync(hs[2]), .vsync(vs[2]), .R(rr[2]), .G(gg[2]), .B(bb[2]),
        .video_on(von[2]), .pix_x(px[2]), .pix_y(py[2]), .frame_start(fs[2]));

    // 3: same geometry, checkerboard and mid-frame reset
    vga_timing_gen_p #(.H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4), .CLK_DIV(1)) u_chk (
        .clk_50(clk), .rst_o(rstn[3]), .sw(swv[3]), .mode(mdv[3]),
        .hsync(hs[3]), .vsync(vs[3]), .R(rr[3]), .G(gg[3]), .B(bb[3]),
        .video_on(von[3]), .pix_x(px[3]), .pix_y(py[3]), .frame_start(fs[3]));

    // 4: tiny timing, H 8/1/2/1 and V 4/1/1/1
    vga_timing_gen_p #(.H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
                       .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .CLK_DIV(1)) u_small (
        .clk_50(clk), .rst_o(rstn[4]), .sw(swv[4]), .mode(mdv[4]),
        .hsync(hs[4]), .vsync(vs[4]), .R(rr[4]), .G(gg[4]), .B(bb[4]),
        .video_on(von[4]), .pix_x(px[4]), .pix_y(py[4]), .frame_start(fs[4]));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] rgb(input int s);
        return {rr[s], gg[s], bb[s]};
    endfunction

    function automatic logic sync_of(input int s, input bit is_v);
        return is_v ? vs[s] : hs[s];
    endfunction

    task automatic check_reset(input int s, input logic hs_idle, input logic vs_idle, input string tag);
        check_eq({tag, "_rst_sync"}, {hs[s], vs[s]}, {hs_idle, vs_idle});
        check_eq({tag, "_rst_flags"}, {von[s], fs[s]}, 2'b00);
        check_eq({tag, "_rst_xy"}, {px[s], py[s]}, 20'd0);
        check_eq({tag, "_rst_rgb"}, rgb(s), 12'h000);
    endtask

    task automatic wait_fs(input int s, input int budget, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (fs[s] !== 1'b1 && n < budget);
        check_eq({tag, "_fs_seen"}, fs[s], 1'b1);
    endtask

    task automatic wait_px(input int s, input int x, input int y, input int budget, input string tag);
        int n = 0;
        logic hit;
        do begin
            @(negedge clk);
            n++;
            hit = (von[s] === 1'b1) && (px[s] == 10'(x)) && (py[s] == 10'(y));
        end while (!hit && n < budget);
        check_eq({tag, "_px_seen"}, hit, 1'b1);
    endtask

    task automatic wait_lvl(input int s, input bit is_v, input logic lvl, inout int b);
        while (sync_of(s, is_v) !== lvl && b > 0) begin
            @(negedge clk);
            b--;
        end
    endtask

    task automatic pulse_width(input int s, input bit is_v, input logic lvl, input int budget, output int width);
        int b = budget;
        width = 0;
        wait_lvl(s, is_v, ~lvl, b);
        wait_lvl(s, is_v, lvl, b);
        while (sync_of(s, is_v) === lvl && b > 0) begin
            width++;
            @(negedge clk);
            b--;
        end
    endtask

    task automatic edge_period(input int s, input bit is_v, input logic lvl, input int budget, output int period);
        int b = budget;
        int t1;
        wait_lvl(s, is_v, ~lvl, b);
        wait_lvl(s, is_v, lvl, b);
        t1 = cyc;
        wait_lvl(s, is_v, ~lvl, b);
        wait_lvl(s, is_v, lvl, b);
        period = (b > 0) ? (cyc - t1) : -1;
    endtask

    initial begin
        swv[0] = 4'h9;
        swv[2] = 4'hC;
        swv[3] = 4'hF;
        swv[4] = 4'h4;
        mdv[3] = 2'd2;
        fork
            begin : t_def
                int w;
                int p;
                repeat (3) @(negedge clk);
                check_reset(0, 1'b1, 1'b1, "def");
                rstn[0] = 1'b1;
                @(negedge clk);
                check_eq("def_first_fs", {fs[0], von[0]}, 2'b11);
                check_eq("def_first_rgb", rgb(0), 12'h55F);
                @(negedge clk);
                check_eq("def_fs_hold_tick", fs[0], 1'b1);
                @(negedge clk);
                check_eq("def_fs_drop", {fs[0], px[0]}, {1'b0, 10'd1});
                swv[0] = 4'h2;
                @(negedge clk);
                check_eq("def_sw_between_ticks", rgb(0), 12'h55F);
                @(negedge clk);
                check_eq("def_sw_next_tick", {px[0], rgb(0)}, {10'd2, 12'h0A0});
                pulse_width(0, 1'b0, 1'b0, 4000, w);
                check_eq("def_hsync_width", w, 192);
                check_eq("def_blank_after_hs", {von[0], rgb(0)}, 13'd0);
                edge_period(0, 1'b0, 1'b0, 5000, p);
                check_eq("def_line_period", p, 1600);
                check_eq("def_vsync_idle", vs[0], 1'b1);
            end
            begin : t_pol
                int w;
                int p;
                repeat (3) @(negedge clk);
                check_reset(1, 1'b0, 1'b0, "pol");
                rstn[1] = 1'b1;
                pulse_width(1, 1'b0, 1'b1, 3000, w);
                check_eq("pol_hsync_width", w, 96);
                edge_period(1, 1'b0, 1'b1, 3000, p);
                check_eq("pol_line_period", p, 800);
                check_eq("pol_vsync_idle", vs[1], 1'b0);
            end
            begin : t_mid
                int w;
                int t0;
                repeat (3) @(negedge clk);
                check_reset(2, 1'b1, 1'b1, "mid");
                rstn[2] = 1'b1;
                wait_fs(2, 4, "mid_first");
                t0 = cyc;
                check_eq("mid_solid_origin", rgb(2), 12'hF55);
                wait_px(2, 0, 200, 20000, "mid_y200");
                mdv[2] = 2'd1;
                wait_px(2, 28, 200, 100, "mid_x28_y200");
                check_eq("mid_no_tear_200", rgb(2), 12'hF55);
                wait_px(2, 28, 201, 200, "mid_x28_y201");
                check_eq("mid_no_tear_201", rgb(2), 12'hF55);
                pulse_width(2, 1'b1, 1'b0, 30000, w);
                check_eq("mid_vsync_width", w, 160);
                wait_fs(2, 5000, "mid_second");
                check_eq("mid_frame_period", cyc - t0, 42000);
                check_eq("mid_bar0", rgb(2), 12'h000);
                wait_px(2, 23, 0, 100, "mid_x23");
                check_eq("mid_bar2_edge", rgb(2), 12'h0A0);
                wait_px(2, 24, 0, 100, "mid_x24");
                check_eq("mid_bar3_start", rgb(2), 12'h0AA);
                wait_px(2, 31, 0, 100, "mid_x31");
                check_eq("mid_bar3_end", rgb(2), 12'h0AA);
                wait_px(2, 32, 0, 100, "mid_x32");
                check_eq("mid_bar4_start", rgb(2), 12'hA00);
            end
            begin : t_chk
                repeat (3) @(negedge clk);
                check_reset(3, 1'b1, 1'b1, "chk");
                rstn[3] = 1'b1;
                wait_fs(3, 4, "chk_first");
                wait_px(3, 31, 0, 100, "chk_31_0");
                check_eq("chk_31_0_rgb", rgb(3), 12'hFFF);
                wait_px(3, 32, 0, 100, "chk_32_0");
                check_eq("chk_32_0_rgb", rgb(3), 12'h000);
                wait_px(3, 0, 32, 3000, "chk_0_32");
                check_eq("chk_0_32_rgb", rgb(3), 12'h000);
                wait_px(3, 32, 32, 100, "chk_32_32");
                check_eq("chk_32_32_rgb", rgb(3), 12'hFFF);
                wait_px(3, 50, 300, 30000, "chk_50_300");
                rstn[3] = 1'b0;
                @(negedge clk);
                check_reset(3, 1'b1, 1'b1, "chk_mid1");
                repeat (2) @(negedge clk);
                check_reset(3, 1'b1, 1'b1, "chk_mid3");
                rstn[3] = 1'b1;
                @(negedge clk);
                check_eq("chk_restart_fs", {fs[3], von[3]}, 2'b11);
                check_eq("chk_restart_xy", {px[3], py[3]}, 20'd0);
                check_eq("chk_restart_rgb", rgb(3), 12'hFFF);
            end
            begin : t_small
                repeat (3) @(negedge clk);
                check_reset(4, 1'b1, 1'b1, "small");
                rstn[4] = 1'b1;
                for (int k = 0; k < 100; k++) begin
                    int hc;
                    int vc;
                    logic act;
                    @(negedge clk);
                    hc  = k % 12;
                    vc  = (k / 12) % 7;
                    act = (hc < 8) && (vc < 4);
                    check_eq($sformatf("small_sync_k%0d", k), {hs[4], vs[4], von[4], fs[4]},
                             {(hc == 9 || hc == 10) ? 1'b0 : 1'b1, (vc == 5) ? 1'b0 : 1'b1,
                              act, (hc == 0 && vc == 0)});
                    check_eq($sformatf("small_xy_k%0d", k), {px[4], py[4]},
                             {act ? 10'(hc) : 10'd0, act ? 10'(vc) : 10'd0});
                    check_eq($sformatf("small_rgb_k%0d", k), rgb(4), act ? 12'hA00 : 12'h000);
                end
            end
        join
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen_p.md
VGA_TIMING_GEN_P -- requirements
Module: vga_timing_gen_p

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-low reset.
REQ-002 Parameters SHALL be, one per line, as listed below.
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- HS_POL, 0, hsync active level
- VS_POL, 0, vsync active level
- CLK_DIV, 2, clk_50 cycles per pixel (at least 1)
- COLOR_W, 4, bits per colour channel
REQ-003 Ports SHALL be, one per line, name, direction, width, meaning:
- clk_50, in, 1, system clock
- rst_o, in, 1, synchronous active-low reset
- sw, in, 4, palette index
- mode, in, 2, pattern select
- hsync, out, 1, horizontal sync
- vsync, out, 1, vertical sync
- R, G, B, out, COLOR_W each, colour
- video_on, out, 1, active-region flag
- pix_x, pix_y, out, 10 each, current active coordinate
- frame_start, out, 1, one-pixel pulse at the first active pixel

Function
REQ-004 A divider SHALL assert pix_en once every CLK_DIV clk_50 cycles; with CLK_DIV=1, pix_en SHALL be held high.
- All counter and output updates occur only on pix_en cycles.
REQ-005 The horizontal counter hc SHALL run from 0 to H_TOTAL-1, where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP, then wrap to 0.
REQ-006 The vertical counter vc SHALL advance only on pix_en cycles where hc=H_TOTAL-1, SHALL wrap from V_TOTAL-1 to 0, and SHALL increment together with the hc wrap in the same cycle.
REQ-007 The timing regions SHALL be defined from counter 0 as:
- Active region: hc<H_ACTIVE.
- Sync region: H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC.
- Vertical regions use the same rule with the V_ parameters.
REQ-008 Outputs hsync, vsync, video_on, pix_x, pix_y, frame_start and RGB SHALL be registered with exactly one pixel tick of latency from hc/vc, and all SHALL be mutually aligned.
REQ-009 hsync SHALL equal HS_POL inside the sync region and ~HS_POL outside it; vsync SHALL follow the same rule with VS_POL.
REQ-010 Coordinate and pulse outputs SHALL behave as follows:
- pix_x and pix_y equal hc and vc while video_on=1, and hold 0 otherwise.
- frame_start is 1 for the single pixel tick at hc=0, vc=0.
REQ-011 mode SHALL be captured into mode_q only on the tick where hc=0 and vc=0, so a pattern change never tears mid-frame.
REQ-012 The pattern SHALL be selected by mode_q:
- 0: solid PALETTE[sw].
- 1: eight vertical bars of width H_ACTIVE/8, bar n shown as PALETTE[n].
- 2: 32x32 checkerboard, alternating PALETTE[sw] and black, selected by pix_x[5]^pix_y[5].
- 3: gradient with R=pix_x[9:10-COLOR_W], G=pix_y[9:10-COLOR_W], B=0.
REQ-013 R, G and B SHALL be all-zero whenever video_on=0.
REQ-014 sw SHALL be sampled every pixel tick with no frame latching.

Reset
REQ-015 While rst_o=0 at a clk_50 edge, the block SHALL load:
- the divider, hc, vc and mode_q with 0;
- hsync with ~HS_POL and vsync with ~VS_POL;
- video_on, frame_start, pix_x, pix_y, R, G and B with 0.
REQ-016 A reset asserted mid-line or mid-frame SHALL take effect on the next edge, after which the block SHALL restart at hc=0, vc=0 with mode_q=0.
REQ-017 The first frame_start after release SHALL occur one pixel tick later, and that frame SHALL latch mode.

Structure
REQ-018 A shared package vga_pkg SHALL hold:
- the 640x480 default timing constants and the derived H_TOTAL/V_TOTAL function;
- the 16-entry 12-bit PALETTE, scaled to COLOR_W by dropping the LSBs;
- the mode encoding constants.
REQ-019 The sub-module vga_pattern_gen SHALL be combinational and SHALL map mode_q, sw, pix_x and pix_y to RGB; timing and registering SHALL stay in the top level.

Verification
REQ-020 The bench SHALL cover at least these directed scenarios:
- Default parameters, CLK_DIV=2: the hsync low pulse lasts 192 clk_50 cycles, the line lasts 1600, vsync is low for 2 lines per 525, and frame_start recurs every 840000 cycles.
- HS_POL=1, VS_POL=1, CLK_DIV=1: sync polarities are inverted and the line period is 800 cycles.
- mode changed from 0 to 1 at vc=200: the output stays solid until the next frame_start, then bar 3 (pix_x 240..319) shows PALETTE[3].
- mode=2, sw=4'hF: pixel (31,0) is PALETTE[15], (32,0) is black, and (32,32) is PALETTE[15].
- rst_o low for 3 cycles at hc=500, vc=300: all outputs go to reset values, and the next frame_start comes one pixel tick after release.
- Small parameters (H 8/1/2/1, V 4/1/1/1): wrap at hc=11 and vc=6, the vc increment coincides with the hc wrap, and video_on is low outside active and RGB is 0 in blanking.
